// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator CPU microsequencer: opcodes, strobe
// indices, FSM state encoding and ALU function codes.
package cpu_ctrl_pkg;

  localparam int NUM_CTRL = 15;

  localparam int C_PC_INC  = 0;
  localparam int C_PC_MAR  = 1;
  localparam int C_MEM_RD  = 2;
  localparam int C_MBR_PC  = 3;
  localparam int C_MBR_IR  = 4;
  localparam int C_UNUSED  = 5;
  localparam int C_MBR_BR  = 6;
  localparam int C_ALU_ACC = 7;
  localparam int C_MBR_MAR = 8;
  localparam int C_ACC_MBR = 9;
  localparam int C_ALU_EN  = 10;
  localparam int C_MBR_ACC = 11;
  localparam int C_MEM_WR  = 12;
  localparam int C_MBR_BUS = 13;
  localparam int C_ACC_CLR = 14;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_STORE = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_JGZ   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_HALT  = 8'h07;
  localparam logic [7:0] OP_MPY   = 8'h08;
  localparam logic [7:0] OP_AND   = 8'h0A;
  localparam logic [7:0] OP_OR    = 8'h0B;

  // S_CLR is the single ACC-clear cycle between IDLE and the first fetch.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F1     = 4'd1,
    S_F2     = 4'd2,
    S_F3     = 4'd3,
    S_DEC    = 4'd4,
    S_E_MAR  = 4'd5,
    S_E_RD   = 4'd6,
    S_E_LD   = 4'd7,
    S_E_BR   = 4'd8,
    S_E_ALU  = 4'd9,
    S_E_ACC  = 4'd10,
    S_E_WR   = 4'd11,
    S_E_JMP  = 4'd12,
    S_HALTED = 4'd13,
    S_CLR    = 4'd14
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_MPY = 3'd4
  } alu_op_t;

  function automatic alu_op_t alu_of(input logic [7:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_MPY:  return ALU_MPY;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic op_defined(input logic [7:0] op);
    case (op)
      OP_NOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_JGZ,
      OP_JMP, OP_HALT, OP_MPY, OP_AND, OP_OR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_unit_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access; flags the cycle on
// which the wait budget runs out with the memory still not ready.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = i_en && (r_count == LIMIT);

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute microsequencer for the 16-bit accumulator CPU; drives
// the datapath strobes C0..C14 as Moore outputs of the registered state.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int START_PC_WAIT = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [7:0]          i_opcode,
  input  logic                i_acc_pos,
  input  logic                i_mem_ready,
  output logic [NUM_CTRL-1:0] o_ctrl,
  output logic [2:0]          o_alu_op,
  output logic                o_halt,
  output logic                o_bus_err,
  output logic                o_illegal,
  output logic [3:0]          o_state
);

  localparam logic [1:0] START_LOAD = (START_PC_WAIT > 0) ? 2'(START_PC_WAIT - 1) : 2'd0;

  state_t     r_state;
  logic [7:0] r_opcode;
  logic       r_bus_err;
  logic       r_start_pend;
  logic [1:0] r_start_cnt;
  logic       w_in_wait;
  logic       w_expired;

  assign w_in_wait = (r_state == S_F2) || (r_state == S_E_RD) || (r_state == S_E_WR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!w_in_wait),
    .i_en      (w_in_wait && !i_mem_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_opcode     <= OP_NOP;
      r_bus_err    <= 1'b0;
      r_start_pend <= 1'b0;
      r_start_cnt  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_start_pend) begin
            if (r_start_cnt == 2'd0) begin
              r_start_pend <= 1'b0;
              r_state      <= S_CLR;
            end else begin
              r_start_cnt <= r_start_cnt - 2'd1;
            end
          end else if (i_start) begin
            if (START_PC_WAIT == 0) begin
              r_state <= S_CLR;
            end else begin
              r_start_pend <= 1'b1;
              r_start_cnt  <= START_LOAD;
            end
          end
        end
        S_CLR: r_state <= S_F1;
        S_F1:  r_state <= S_F2;
        S_F2: begin
          if (i_mem_ready) begin
            r_state <= S_F3;
          end else if (w_expired) begin
            r_state   <= S_HALTED;
            r_bus_err <= 1'b1;
          end
        end
        S_F3: r_state <= S_DEC;
        S_DEC: begin
          r_opcode <= i_opcode;
          case (i_opcode)
            OP_STORE, OP_LOAD, OP_ADD, OP_SUB,
            OP_MPY, OP_AND, OP_OR:            r_state <= S_E_MAR;
            OP_JGZ:                           r_state <= i_acc_pos ? S_E_JMP : S_F1;
            OP_JMP:                           r_state <= S_E_JMP;
            OP_HALT:                          r_state <= S_HALTED;
            default:                          r_state <= S_F1;
          endcase
        end
        S_E_MAR: r_state <= (r_opcode == OP_STORE) ? S_E_ACC : S_E_RD;
        S_E_RD: begin
          if (i_mem_ready) begin
            r_state <= (r_opcode == OP_LOAD) ? S_E_LD : S_E_BR;
          end else if (w_expired) begin
            r_state   <= S_HALTED;
            r_bus_err <= 1'b1;
          end
        end
        S_E_LD:  r_state <= S_F1;
        S_E_BR:  r_state <= S_E_ALU;
        S_E_ALU: r_state <= S_F1;
        S_E_ACC: r_state <= S_E_WR;
        S_E_WR: begin
          if (i_mem_ready) begin
            r_state <= S_F1;
          end else if (w_expired) begin
            r_state   <= S_HALTED;
            r_bus_err <= 1'b1;
          end
        end
        S_E_JMP:  r_state <= S_F1;
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ctrl = '0;
    case (r_state)
      S_CLR:   o_ctrl[C_ACC_CLR] = 1'b1;
      S_F1:    o_ctrl[C_PC_MAR]  = 1'b1;
      S_F2:    o_ctrl[C_MEM_RD]  = 1'b1;
      S_F3: begin
        o_ctrl[C_MBR_IR] = 1'b1;
        o_ctrl[C_PC_INC] = 1'b1;
      end
      S_E_MAR: o_ctrl[C_MBR_MAR] = 1'b1;
      S_E_RD:  o_ctrl[C_MEM_RD]  = 1'b1;
      S_E_LD:  o_ctrl[C_MBR_ACC] = 1'b1;
      S_E_BR:  o_ctrl[C_MBR_BR]  = 1'b1;
      S_E_ALU: begin
        o_ctrl[C_ALU_EN]  = 1'b1;
        o_ctrl[C_ALU_ACC] = 1'b1;
      end
      S_E_ACC: o_ctrl[C_ACC_MBR] = 1'b1;
      S_E_WR: begin
        o_ctrl[C_MEM_WR]  = 1'b1;
        o_ctrl[C_MBR_BUS] = 1'b1;
      end
      S_E_JMP: o_ctrl[C_MBR_PC]  = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

  assign o_alu_op  = (r_state == S_E_ALU) ? alu_of(r_opcode) : ALU_ADD;
  assign o_halt    = (r_state == S_HALTED);
  assign o_bus_err = r_bus_err;
  assign o_illegal = (r_state == S_DEC) && !op_defined(i_opcode);
  assign o_state   = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench: the stimulus queues the expected per-cycle outputs, a
// negedge monitor pops and compares them against the DUT.
module tb_cpu_control_unit;

  localparam logic [14:0] C0  = 15'h0001;
  localparam logic [14:0] C1  = 15'h0002;
  localparam logic [14:0] C2  = 15'h0004;
  localparam logic [14:0] C3  = 15'h0008;
  localparam logic [14:0] C4  = 15'h0010;
  localparam logic [14:0] C6  = 15'h0040;
  localparam logic [14:0] C7  = 15'h0080;
  localparam logic [14:0] C8  = 15'h0100;
  localparam logic [14:0] C9  = 15'h0200;
  localparam logic [14:0] C10 = 15'h0400;
  localparam logic [14:0] C11 = 15'h0800;
  localparam logic [14:0] C12 = 15'h1000;
  localparam logic [14:0] C13 = 15'h2000;
  localparam logic [14:0] C14 = 15'h4000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_opcode = 8'h00;
  logic        i_acc_pos = 1'b0;
  logic        i_mem_ready = 1'b0;
  logic [14:0] o_ctrl;
  logic [2:0]  o_alu_op;
  logic        o_halt;
  logic        o_bus_err;
  logic        o_illegal;
  logic [3:0]  o_state;

  cpu_control_unit #(.MEM_TIMEOUT(4), .START_PC_WAIT(0)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_opcode    (i_opcode),
    .i_acc_pos   (i_acc_pos),
    .i_mem_ready (i_mem_ready),
    .o_ctrl      (o_ctrl),
    .o_alu_op    (o_alu_op),
    .o_halt      (o_halt),
    .o_bus_err   (o_bus_err),
    .o_illegal   (o_illegal),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [14:0] ctrl;
    logic [2:0]  alu;
    logic        halt;
    logic        err;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  m_exp;
  exp_t  m_got;
  string m_tag;

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      m_got = {o_ctrl, o_alu_op, o_halt, o_bus_err, o_illegal};
      checks++;
      if (m_got !== m_exp) begin
        errors++;
        $display("FAIL %s: got ctrl=%h alu=%0d halt=%b err=%b ill=%b, expected ctrl=%h alu=%0d halt=%b err=%b ill=%b",
                 m_tag, m_got.ctrl, m_got.alu, m_got.halt, m_got.err, m_got.ill,
                 m_exp.ctrl, m_exp.alu, m_exp.halt, m_exp.err, m_exp.ill);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic cyc(input string tag, input logic [14:0] c, input logic [2:0] a,
                     input logic h, input logic e, input logic il, input logic st,
                     input logic rdy, input logic [7:0] op, input logic pos);
    exp_t x;
    i_start     = st;
    i_mem_ready = rdy;
    i_opcode    = op;
    i_acc_pos   = pos;
    x.ctrl = c;
    x.alu  = a;
    x.halt = h;
    x.err  = e;
    x.ill  = il;
    exp_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge i_clk);
    #1;
  endtask

  task automatic s(input string tag, input logic [14:0] c, input logic rdy = 1'b1);
    cyc(tag, c, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy, 8'hFF, 1'b0);
  endtask

  task automatic fetch(input string name, input logic [7:0] op, input logic pos,
                       input int waits, input logic ill);
    $display("[%0t] instr %s opcode=%02h acc_pos=%b fetch_waits=%0d", $time, name, op, pos, waits);
    s({name, " F1"}, C1);
    for (int i = 0; i < waits; i++) s({name, " F2 wait"}, C2, 1'b0);
    s({name, " F2"}, C2);
    s({name, " F3"}, C4 | C0);
    cyc({name, " DEC"}, 15'h0, 3'd0, 1'b0, 1'b0, ill, 1'b0, 1'b1, op, pos);
  endtask

  task automatic alu_ex(input string name, input logic [2:0] alu, input int waits);
    s({name, " E_MAR"}, C8);
    for (int i = 0; i < waits; i++) s({name, " E_RD wait"}, C2, 1'b0);
    s({name, " E_RD"}, C2);
    s({name, " E_BR"}, C6);
    cyc({name, " E_ALU"}, C10 | C7, alu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    cyc("reset", 15'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    i_rst_n = 1'b1;
    cyc("idle start", 15'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
    s("acc clear", C14);

    fetch("LOAD", 8'h02, 1'b0, 0, 1'b0);
    s("LOAD E_MAR", C8);
    s("LOAD E_RD", C2);
    s("LOAD E_LD", C11);

    fetch("ADD", 8'h03, 1'b0, 0, 1'b0);
    alu_ex("ADD", 3'd0, 2);
    fetch("SUB", 8'h04, 1'b1, 0, 1'b0);
    alu_ex("SUB", 3'd1, 0);
    fetch("MPY", 8'h08, 1'b0, 0, 1'b0);
    alu_ex("MPY", 3'd4, 0);
    fetch("AND", 8'h0A, 1'b0, 0, 1'b0);
    alu_ex("AND", 3'd2, 1);
    fetch("OR", 8'h0B, 1'b0, 0, 1'b0);
    alu_ex("OR", 3'd3, 0);

    fetch("STORE", 8'h01, 1'b0, 1, 1'b0);
    s("STORE E_MAR", C8);
    s("STORE E_ACC", C9);
    for (int i = 0; i < 3; i++) s("STORE E_WR wait", C12 | C13, 1'b0);
    s("STORE E_WR ready at limit", C12 | C13, 1'b1);

    fetch("JGZ taken", 8'h05, 1'b1, 0, 1'b0);
    s("JGZ E_JMP", C3);
    fetch("JGZ not taken", 8'h05, 1'b0, 0, 1'b0);
    fetch("JMP", 8'h06, 1'b0, 0, 1'b0);
    s("JMP E_JMP", C3);
    fetch("NOP", 8'h00, 1'b1, 0, 1'b0);
    fetch("ILL FF", 8'hFF, 1'b0, 0, 1'b1);
    fetch("ILL 09", 8'h09, 1'b0, 0, 1'b1);

    fetch("HALT", 8'h07, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("halted start ignored", 15'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'(i % 2 == 0), 1'b1, 8'hFF, 1'b0);

    i_rst_n = 1'b0;
    cyc("reset from halt", 15'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    i_rst_n = 1'b1;
    $display("[%0t] instr TIMEOUT fetch with ready held low", $time);
    cyc("idle start 2", 15'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
    s("acc clear 2", C14, 1'b0);
    s("TMO F1", C1, 1'b0);
    for (int i = 0; i < 4; i++) s("TMO F2 wait", C2, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("bus error halt", 15'h0, 3'd0, 1'b1, 1'b1, 1'b0, 1'(i == 1), 1'b1, 8'hFF, 1'b0);

    i_rst_n = 1'b0;
    cyc("reset clears bus err", 15'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
    i_rst_n = 1'b1;
    cyc("idle no start", 15'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);

    repeat (3) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
